// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - multicycle signed 32-bit Booth multiply / non-restoring divide sequencer
module multdiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             data_busy
);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state;
   logic [4:0]       counter;
   logic [WIDTH:0]   acc;       // Booth high word / signed partial remainder
   logic [WIDTH-1:0] q;         // Booth multiplier / dividend-then-quotient
   logic             q_m1;      // Booth q-1 bit
   logic [WIDTH:0]   b_reg;     // sign-extended multiplicand or divisor magnitude
   logic             is_div;
   logic             neg_q;
   logic             div_zero;
   logic             div_ovf;

   logic             start;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   add_x;
   logic [WIDTH:0]   sum;
   logic             add_sub;
   logic [WIDTH:0]   booth_acc;
   logic [WIDTH-1:0] fix_result;
   logic             fix_exc;

   // Start detection and operand magnitudes for divide.
   always_comb begin
      start = ctrl_MULT | ctrl_DIV;
      mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   end

   // Shared 33-bit adder/subtractor: Booth step, divide step, remainder correction.
   always_comb begin
      add_x   = acc;
      add_sub = 1'b0;
      if (state == RUN) begin
         if (is_div) begin
            add_x   = {acc[WIDTH-1:0], q[WIDTH-1]};
            add_sub = ~acc[WIDTH];
         end else begin
            add_sub = q[0] & ~q_m1;
         end
      end
      sum = add_sub ? (add_x - b_reg) : (add_x + b_reg);
      booth_acc = (q[0] ^ q_m1) ? sum : acc;
   end

   // Final result and exception selection used on the FIX to DONE edge.
   always_comb begin
      fix_result = q;
      fix_exc    = 1'b0;
      if (!is_div) begin
         fix_exc = ~((&{acc[WIDTH-2:0], q[WIDTH-1]}) | ~(|{acc[WIDTH-2:0], q[WIDTH-1]}));
      end else if (div_zero) begin
         fix_result = '0;
         fix_exc    = 1'b1;
      end else if (div_ovf) begin
         fix_result = {1'b1, {(WIDTH-1){1'b0}}};
         fix_exc    = 1'b1;
      end else if (neg_q) begin
         fix_result = -q;
      end
   end

   // Sequencer: latch on start (aborting any op in flight), iterate, fix up, pulse ready.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         counter        <= '0;
         acc            <= '0;
         q              <= '0;
         q_m1           <= 1'b0;
         b_reg          <= '0;
         is_div         <= 1'b0;
         neg_q          <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         data_busy      <= 1'b0;
      end else if (start) begin
         state          <= RUN;
         counter        <= '0;
         acc            <= '0;
         q_m1           <= 1'b0;
         is_div         <= ~ctrl_MULT;
         neg_q          <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         div_zero       <= (data_operandB == '0);
         div_ovf        <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
         data_resultRDY <= 1'b0;
         data_busy      <= 1'b1;
         if (ctrl_MULT) begin
            q     <= data_operandA;
            b_reg <= {data_operandB[WIDTH-1], data_operandB};
         end else begin
            q     <= mag_a;
            b_reg <= {1'b0, mag_b};
         end
      end else begin
         case (state)
            IDLE: begin
               data_resultRDY <= 1'b0;
            end
            RUN: begin
               if (is_div) begin
                  acc <= sum;
                  q   <= {q[WIDTH-2:0], ~sum[WIDTH]};
               end else begin
                  acc  <= {booth_acc[WIDTH], booth_acc[WIDTH:1]};
                  q    <= {booth_acc[0], q[WIDTH-1:1]};
                  q_m1 <= q[0];
               end
               if (counter == 5'(WIDTH - 1)) begin
                  state <= FIX;
               end else begin
                  counter <= counter + 5'd1;
               end
            end
            FIX: begin
               if (is_div && acc[WIDTH]) begin
                  acc <= sum;
               end
               data_result    <= fix_result;
               data_exception <= fix_exc;
               data_resultRDY <= 1'b1;
               state          <= DONE;
            end
            DONE: begin
               data_resultRDY <= 1'b0;
               data_busy      <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Multicycle sequencer for signed 32-bit multiply and divide, alongside the single-cycle ALU in the execute stage.
- Accepts a one-cycle start pulse, runs a fixed 32-iteration shift/add-subtract loop on an internal shared 33-bit adder/subtractor, then pulses result-ready.
- The pipeline stalls on data_busy and captures data_result and data_exception when data_resultRDY pulses.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported, and the iteration count equals WIDTH.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; clears all state
data_operandA  input  32  multiplicand / dividend, two's complement
data_operandB  input  32  multiplier / divisor, two's complement
ctrl_MULT  input  1  one-cycle start pulse for multiply
ctrl_DIV  input  1  one-cycle start pulse for divide
data_result  output  32  product low word or quotient
data_exception  output  1  overflow / divide error flag
data_resultRDY  output  1  one-cycle pulse: result and exception valid
data_busy  output  1  high while an operation is in flight

Behaviour:
- Reset is synchronous and active-high, and outranks all other inputs. On reset: state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, data_busy=0.
- States:
  - IDLE: waiting for a start pulse.
  - RUN: 32 iterations, counter 0..31.
  - FIX: sign/overflow correction.
  - DONE: asserts data_resultRDY for one cycle.
- Start:
  - ctrl_MULT or ctrl_DIV high at edge T latches both operands and the op type, and enters RUN.
  - data_busy=1 from T+1 until the end of the DONE cycle.
  - If both are high at once, MULT wins.
  - A start pulse in any non-IDLE state aborts the current op, relatches and restarts. No RDY is issued for the aborted op.
- Latency:
  - Start at edge T. RUN covers cycles T+1..T+32, FIX is T+33, DONE/data_resultRDY is T+34.
  - This holds for every op, including divide-by-zero.
- Multiply:
  - Radix-2 Booth over a 65-bit {A,Q,q-1} register.
  - Each iteration adds +B, -B or 0 according to {Q[0],q-1}, then does an arithmetic right shift.
  - data_result = product[31:0].
  - data_exception = 1 if product[63:31] is not all-zeros or all-ones (32-bit signed overflow).
- Divide:
  - Operands are converted to magnitudes at latch. Non-restoring division runs 32 iterations on the magnitudes, with a remainder correction in FIX.
  - The quotient is negated in FIX if the operand signs differ, so it truncates toward zero. The remainder is not output.
  - Divisor == 0: data_result=0, data_exception=1.
  - Dividend 0x80000000 with divisor 0xFFFFFFFF: data_result=0x80000000, data_exception=1.
- Output holding:
  - data_result and data_exception update only at the DONE edge and hold until the next DONE or reset.
  - data_resultRDY is high for exactly one cycle per completed op.
- Operand inputs are ignored except at the start edge, so they may change freely mid-operation.
- Counter range is 0..31. It is cleared on start and never wraps in RUN, because the transition to FIX happens at counter==31.

Test Plan:
1. ctrl_MULT with A=7, B=-3 (0xFFFFFFFD) -> at T+34, RDY=1, result=0xFFFFFFEB, exc=0; busy falls after that cycle.
2. ctrl_MULT with A=0x00010000, B=0x00010000 -> result=0x00000000, exc=1. Also A=0x7FFFFFFF, B=1 -> result=0x7FFFFFFF, exc=0.
3. Divide sign handling:
   - ctrl_DIV with A=-7, B=2 -> result=0xFFFFFFFD (-3), exc=0.
   - A=100, B=-7 -> result=0xFFFFFFF2 (-14).
4. Divide errors:
   - ctrl_DIV with B=0 -> RDY at T+34, result=0, exc=1.
   - A=0x80000000, B=-1 -> result=0x80000000, exc=1.
5. Abort and reset mid-op:
   - ctrl_MULT(5,5), then ctrl_DIV(9,3) at T+10 -> no RDY near T+34; a single RDY at T+44 with result=3.
   - reset at T+20 of any op -> busy=0, RDY never fires, result=0 next cycle.
6. ctrl_MULT and ctrl_DIV high together with A=6, B=4 -> result=24 (multiply wins). A back-to-back start in the DONE cycle is accepted and completes after a further 34 cycles.
